// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline hazard inputs and the stall/flush controls
// it returns. The master drives hazard info; the slave answers with controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             branch_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rn, id_rm, ex_rd, ex_memread,
        output branch_taken, mem_req, dmem_ready,
        input  pc_write, pc_src, ifid_write, idex_write,
        input  exmem_write, ifid_flush, idex_flush,
        input  exmem_flush, mem_err, stall_cnt
    );

    modport slave (
        input  id_rn, id_rm, ex_rd, ex_memread,
        input  branch_taken, mem_req, dmem_ready,
        output pc_write, pc_src, ifid_write, idex_write,
        output exmem_write, ifid_flush, idex_flush,
        output exmem_flush, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// MEM-stage taken branches, DMEM wait freezes with timeout, stall counting.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15,
    parameter int CNT_W             = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MWAIT   = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [7:0]       wcnt, wcnt_n;
    logic [2:0]       ldcnt, ldcnt_n;
    logic             err_set;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    logic pc_write, pc_src, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush;
    logic hazard, freeze;

    assign hazard = bus.ex_memread && (bus.ex_rd != 5'd31) &&
                    ((bus.ex_rd == bus.id_rn) || (bus.ex_rd == bus.id_rm));
    assign freeze = bus.mem_req && !bus.dmem_ready;

    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_n     = state;
        wcnt_n      = '0;
        ldcnt_n     = ldcnt;
        err_set     = 1'b0;
        if (!reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == HALT) begin
            wcnt_n = wcnt;
        end else if (freeze) begin
            wcnt_n = wcnt + 8'd1;
            if (wcnt_n == 8'(MEM_TIMEOUT)) begin
                state_n = HALT;
                err_set = 1'b1;
            end else begin
                state_n = MWAIT;
            end
        end else if (bus.branch_taken) begin
            // Flush the three younger stages and redirect to the target
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_n     = RUN;
        end else if (state == LDSTALL) begin
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            idex_flush  = 1'b1;
            ldcnt_n     = ldcnt - 3'd1;
            if (ldcnt == 3'd1)
                state_n = RUN;
        end else if (hazard) begin
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            idex_flush  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_n = LDSTALL;
                ldcnt_n = 3'(LOAD_STALL_CYCLES - 1);
            end else begin
                state_n = RUN;
            end
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            state_n     = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wcnt      <= '0;
            ldcnt     <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            ldcnt <= ldcnt_n;
            if (err_set)
                mem_err <= 1'b1;
            if (!pc_write && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.ifid_write  = ifid_write;
    assign bus.idex_write  = idex_write;
    assign bus.exmem_write = exmem_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.mem_err     = mem_err;
    assign bus.stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, DMEM
// wait, branch-under-freeze and timeout/HALT sequences.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .LOAD_STALL_CYCLES(2),
        .MEM_TIMEOUT(15),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    localparam logic [7:0] C_RST    = 8'b0000_0111;
    localparam logic [7:0] C_NORM   = 8'b1011_1000;
    localparam logic [7:0] C_BUBBLE = 8'b0001_1010;
    localparam logic [7:0] C_BRANCH = 8'b1111_1111;
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;

    logic [7:0] ctl;
    assign ctl = {bus.pc_write, bus.pc_src, bus.ifid_write,
                  bus.idex_write, bus.exmem_write, bus.ifid_flush,
                  bus.idex_flush, bus.exmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.id_rn        = 5'd0;
        bus.id_rm        = 5'd0;
        bus.ex_rd        = 5'd0;
        bus.ex_memread   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.dmem_ready   = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("reset_ctl", int'(ctl), int'(C_RST));
        chk("reset_cnt", int'(bus.stall_cnt), 0);
        chk("reset_err", int'(bus.mem_err), 0);
        reset = 1'b1;
        #1 chk("run_ctl", int'(ctl), int'(C_NORM));
        @(negedge clk);
        chk("run_ctl2", int'(ctl), int'(C_NORM));
        chk("run_cnt", int'(bus.stall_cnt), 0);

        // load-use on Rm, two bubbles
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd5;
        bus.id_rm      = 5'd5;
        #1 chk("ld_bub1", int'(ctl), int'(C_BUBBLE));
        @(negedge clk);
        idle();
        #1 chk("ld_bub2", int'(ctl), int'(C_BUBBLE));
        @(negedge clk);
        chk("ld_done", int'(ctl), int'(C_NORM));
        chk("ld_cnt", int'(bus.stall_cnt), 2);

        // XZR never creates a hazard
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd31;
        bus.id_rn      = 5'd31;
        #1 chk("xzr_ctl", int'(ctl), int'(C_NORM));
        @(negedge clk);
        idle();
        chk("xzr_cnt", int'(bus.stall_cnt), 2);

        // branch overrides a same-cycle load-use hazard
        bus.ex_memread   = 1'b1;
        bus.ex_rd        = 5'd7;
        bus.id_rn        = 5'd7;
        bus.branch_taken = 1'b1;
        #1 chk("br_ctl", int'(ctl), int'(C_BRANCH));
        @(negedge clk);
        idle();
        #1 chk("br_after", int'(ctl), int'(C_NORM));
        chk("br_cnt", int'(bus.stall_cnt), 2);

        // four-cycle DMEM wait
        bus.mem_req    = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mw_frz%0d", i), int'(ctl), int'(C_FROZEN));
            @(negedge clk);
        end
        bus.dmem_ready = 1'b1;
        #1 chk("mw_rel", int'(ctl), int'(C_NORM));
        chk("mw_cnt", int'(bus.stall_cnt), 6);
        chk("mw_err", int'(bus.mem_err), 0);
        @(negedge clk);
        idle();

        // branch held across a three-cycle freeze
        bus.mem_req      = 1'b1;
        bus.dmem_ready   = 1'b0;
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bf_frz%0d", i), int'(ctl), int'(C_FROZEN));
            @(negedge clk);
        end
        bus.dmem_ready = 1'b1;
        #1 chk("bf_rel", int'(ctl), int'(C_BRANCH));
        @(negedge clk);
        idle();
        #1 chk("bf_after", int'(ctl), int'(C_NORM));
        chk("bf_cnt", int'(bus.stall_cnt), 9);

        // DMEM timeout into HALT
        bus.mem_req    = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1 chk($sformatf("to_frz%0d", i), int'(ctl), int'(C_FROZEN));
            chk($sformatf("to_err%0d", i), int'(bus.mem_err), 0);
            @(negedge clk);
        end
        chk("to_err", int'(bus.mem_err), 1);
        chk("to_cnt", int'(bus.stall_cnt), 24);
        idle();
        bus.branch_taken = 1'b1;
        #1 chk("halt_ctl", int'(ctl), int'(C_FROZEN));
        @(negedge clk);
        chk("halt_ctl2", int'(ctl), int'(C_FROZEN));
        chk("halt_cnt", int'(bus.stall_cnt), 24);
        chk("halt_err", int'(bus.mem_err), 1);
        idle();

        // asynchronous reset out of HALT
        #2 reset = 1'b0;
        #1 chk("rst2_err", int'(bus.mem_err), 0);
        chk("rst2_cnt", int'(bus.stall_cnt), 0);
        chk("rst2_ctl", int'(ctl), int'(C_RST));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_run", int'(ctl), int'(C_NORM));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. It drives write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits (including a timeout). It also counts stall cycles for performance debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 15, max consecutive DMEM wait cycles before error (1..255)
CNT_W, 16, width of stall counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
ID_RN  in  5  first source register of instruction in ID
ID_RM  in  5  second source register (Rt for stores/CBZ) of instruction in ID
EX_RD  in  5  destination register of instruction in EX
EX_MEMREAD  in  1  instruction in EX is a load
BRANCH_TAKEN  in  1  branch in MEM resolved taken (BRANCH_ZERO_OUT & ZERO_OUT)
MEM_REQ  in  1  instruction in MEM reads or writes data memory
DMEM_READY  in  1  data memory completes access this cycle
PC_WRITE  out  1  PC load enable
PC_SRC  out  1  1 = PC loads branch target
IFID_WRITE  out  1  IF/ID load enable
IDEX_WRITE  out  1  ID/EX load enable
EXMEM_WRITE  out  1  EX/MEM load enable
IFID_FLUSH  out  1  IF/ID loads NOP
IDEX_FLUSH  out  1  ID/EX loads bubble (all control bits 0)
EXMEM_FLUSH  out  1  EX/MEM loads bubble
MEM_ERR  out  1  sticky DMEM timeout flag
STALL_CNT  out  CNT_W  saturating count of cycles with PC_WRITE=0

Behaviour:
- States: RUN, LDSTALL, MWAIT, HALT. Outputs are Mealy: a function of the current state and the current inputs.
- Reset (RESET=0, asynchronous):
  - State goes to RUN; internal counters clear.
  - MEM_ERR=0, STALL_CNT=0.
  - All *_WRITE=0, all *_FLUSH=1, PC_SRC=0.
- Default in RUN with no event: all *_WRITE=1, all *_FLUSH=0, PC_SRC=0.
- Hazard definition: hazard = EX_MEMREAD & EX_RD != 31 & (EX_RD == ID_RN | EX_RD == ID_RM). X31 is XZR and never creates a hazard.
- Priority, highest first: HALT > memory wait > branch taken > load-use > normal.
- Memory wait (any state except HALT), when MEM_REQ & !DMEM_READY:
  - Freeze the whole pipeline: all *_WRITE=0, all *_FLUSH=0.
  - Go to (or stay in) MWAIT; the wait counter increments.
- MWAIT:
  - Exits when DMEM_READY=1. The exit cycle behaves as RUN evaluation: branch, hazard and normal priority all apply.
  - If the wait counter reaches MEM_TIMEOUT with DMEM_READY still 0: MEM_ERR is set, next state is HALT.
  - The wait counter clears on exit.
- Load-use stall:
  - The detection cycle is bubble 1: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1; IDEX_WRITE and EXMEM_WRITE stay 1.
  - If LOAD_STALL_CYCLES>1, go to LDSTALL with the remaining count = LOAD_STALL_CYCLES-1.
  - LDSTALL repeats the same outputs each cycle, independent of the current hazard inputs, until the count hits 0, then returns to RUN.
- Branch taken (not frozen):
  - PC_SRC=1, PC_WRITE=1; IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1.
  - Any load-use detection in the same cycle is ignored.
  - In LDSTALL, the branch aborts the stall and returns to RUN.
- HALT: all *_WRITE=0, flushes 0, PC_SRC=0. Exits only via reset; MEM_ERR holds 1.
- STALL_CNT:
  - Increments on each rising edge where PC_WRITE=0, RESET=1 and state != HALT.
  - Saturates at 2^CNT_W-1 with no wrap.
- BRANCH_TAKEN asserted during a freeze is held by the frozen EX/MEM register; it takes effect in the release cycle.

Test Plan:
- Reset, then release with no events -> reset cycle: *_WRITE=0, *_FLUSH=1; next cycle all *_WRITE=1, flushes 0, STALL_CNT=0.
- EX_MEMREAD=1, EX_RD=5, ID_RM=5, LOAD_STALL_CYCLES=2 -> PC_WRITE=IFID_WRITE=0 and IDEX_FLUSH=1 for exactly 2 cycles, then RUN; STALL_CNT=2. Repeat with EX_RD=ID_RN=31 -> no stall.
- Hazard and BRANCH_TAKEN=1 in the same cycle -> PC_SRC=1, PC_WRITE=1, three flushes=1, no stall, STALL_CNT unchanged.
- MEM_REQ=1, DMEM_READY=0 for 4 cycles then 1 -> all *_WRITE=0 for 4 cycles, normal in cycle 5, STALL_CNT=4, MEM_ERR=0.
- MEM_REQ=1, DMEM_READY held 0 with MEM_TIMEOUT=15 -> MEM_ERR=1 after 15 wait cycles, then HALT; all enables stay 0 until RESET=0, which clears MEM_ERR asynchronously.
- Branch taken while frozen (DMEM_READY=0 for 3 cycles) -> no flush during the freeze; flush and PC_SRC=1 in the cycle DMEM_READY=1.
